fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle/pipelined MIPS core.
- Drives the word address into the asynchronous instruction ROM and captures the returned word in the same cycle.
- Buffers fetched words with their PCs in a small in-order queue, presenting them to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- DEPTH, 2, instruction queue entries; power of two, 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction ROM; equals the PC register, combinational from it.
- imem_data  input  32  instruction word from ROM, valid in the same cycle as imem_addr.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  target PC; bits [1:0] ignored (forced to 0).
- dec_ready  input  1  decode accepts the head entry this cycle.
- inst_valid  output  1  queue non-empty; head entry is presented.
- inst  output  32  head instruction word; 0 when empty.
- inst_pc  output  32  PC of head instruction; 0 when empty.
- inst_pc4  output  32  inst_pc + 4 (mod 2^32); 0 when empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): pc = RESET_PC, queue emptied (count = 0, read/write pointers = 0), inst_valid = 0, inst = 0, inst_pc = 0, inst_pc4 = 0.
- pop = inst_valid & dec_ready.
- push = !redirect_valid & (count < DEPTH | pop).
- On push, at the clock edge:
  - write {pc, imem_data} at the write pointer;
  - pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0);
  - ROM aliasing above 4 KB is the ROM's concern.
- On pop: advance the read pointer.
- count update: count <= count + push - pop.
- Pointers wrap modulo DEPTH.
- Full queue without pop: no push; pc holds; imem_addr stable.
- Full queue with pop: push and pop both occur in the same cycle; count unchanged.
- Empty queue: inst_valid = 0; dec_ready is ignored and no pop occurs.
- Latency: a word fetched in cycle N is presented (inst_valid = 1) in cycle N+1. After reset release, mem[RESET_PC] is valid on the first cycle after the first clock edge.
- Redirect:
  - at the edge: pc <= {redirect_pc[31:2], 2'b00}, queue flushed (count = 0), no push;
  - redirect overrides a simultaneous pop and a simultaneous push;
  - the target word is presented 2 cycles after the redirect cycle (fetched in the next cycle, presented the one after).
- Back-to-back redirects: the last one wins; the queue stays empty while redirect_valid is held.
- Outputs inst, inst_pc and inst_pc4 are driven from the head entry, gated to 0 when the queue is empty.
- No X propagation from an empty queue.
- inst_pc4 is computed from the stored PC and does not depend on the live pc.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt, 32 bits: counts cycles with push = 1;
  - perf_stall_cnt, 32 bits: counts cycles with count == DEPTH & !pop & !redirect_valid.
- Both counters reset to 0 on reset and wrap modulo 2^32.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Sequential fetch: ROM holds word k = 0x1000_0000 + k; dec_ready = 1; release reset. Required: inst_valid rises 1 cycle after the first edge, then inst = 0x1000_0000, 0x1000_0001, ... each cycle, with inst_pc = 0, 4, 8, ... and inst_pc4 = inst_pc + 4.
- Backpressure: dec_ready = 0 for 6 cycles. Required: queue holds 2 entries (pc 0x0, 0x4); imem_addr stuck at 0x8; inst stays 0x1000_0000. After dec_ready = 1, the sequence continues gap-free with pc 0x8 next.
- Redirect: pulse redirect_valid with redirect_pc = 0x0000_0043 while the queue is full. Required: next cycle inst_valid = 0 and imem_addr = 0x40; the cycle after, inst_pc = 0x40 and inst = word 16.
- Redirect coinciding with pop and full queue: the popped entry is not repeated; no stale entry (pc 0x4) ever appears after the flush.
- Async reset mid-stream: assert reset between edges with 2 entries queued. Required: inst_valid = 0, inst = 0, imem_addr = RESET_PC immediately, before the next edge.
- Wrap: RESET_PC = 0xFFFF_FFF8, dec_ready = 1. Required: inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc4 for the second entry = 0x0000_0000. With FETCH_PERF_EN, perf_fetch_cnt = 3 after 3 pushes.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into the async ROM and queues {pc, word} pairs for decode.
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_reg, pc_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop;

    logic [31:0]   entry_pc   [DEPTH];
    logic [31:0]   entry_inst [DEPTH];

    assign imem_addr  = pc_reg;
    assign inst_valid = (count_reg != '0);

    always_comb begin
        pop  = inst_valid & dec_ready;
        push = !redirect_valid & ((count_reg < DEPTH_C) | pop);
    end

    always_comb begin
        pc_next     = pc_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (redirect_valid) begin
            // Flush wins over any push/pop in the same cycle.
            pc_next     = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                pc_next     = pc_reg + 32'd4;
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            pc_reg     <= pc_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload slots carry no reset; the head outputs are gated while empty.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] slot_pc_reg;
            logic [31:0] slot_inst_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    slot_pc_reg   <= pc_reg;
                    slot_inst_reg <= imem_data;
                end
            end

            assign entry_pc[gi]   = slot_pc_reg;
            assign entry_inst[gi] = slot_inst_reg;
        end
    endgenerate

    always_comb begin
        inst     = '0;
        inst_pc  = '0;
        inst_pc4 = '0;
        if (inst_valid) begin
            inst     = entry_inst[rd_ptr_reg];
            inst_pc  = entry_pc[rd_ptr_reg];
            inst_pc4 = entry_pc[rd_ptr_reg] + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    logic stall;
    assign stall = (count_reg == DEPTH_C) & !pop & !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, directed scenarios plus random redirect/backpressure.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, inst_pc4;

    logic        reset2 = 1'b1;
    logic [31:0] imem_addr2, imem_data2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        dec_ready2 = 1'b0;
    logic        inst_valid2;
    logic [31:0] inst2, inst_pc2, inst_pc42;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt2, perf_stall_cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_data  = rom(imem_addr);
    assign imem_data2 = rom(imem_addr2);

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .dec_ready(dec_ready2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .inst_pc4(inst_pc42)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt2), .perf_stall_cnt(perf_stall_cnt2)
`endif
    );

    // Reference model: an in-order list of {pc, word} plus the fetch PC.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch, m_stall;

    function automatic logic [128:0] m_out();
        if (mq.size() == 0) return {1'b0, 96'b0, m_pc};
        return {1'b1, mq[0][31:0], mq[0][63:32], mq[0][63:32] + 32'd4, m_pc};
    endfunction

    logic [128:0] dut_out;
    assign dut_out = {inst_valid, inst, inst_pc, inst_pc4, imem_addr};

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fetch = 32'h0;
        m_stall = 32'h0;
    endtask

    task automatic tick(input logic rv, input logic [31:0] rpc, input logic dr);
        bit pop, push;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = dr;
        pop  = (mq.size() != 0) && dr;
        push = !rv && ((mq.size() < 2) || pop);
        if (pop) $display("pop pc=%h inst=%h", mq[0][63:32], mq[0][31:0]);
        m_fetch = m_fetch + 32'(push);
        if (mq.size() == 2 && !pop && !rv) m_stall = m_stall + 32'd1;
        if (rv) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_out !== {1'b0, 96'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", dut_out, {1'b0, 96'b0, 32'h0});
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 32'h0, 1'b1);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL seq_model k=%0d got=%h exp=%h", k, dut_out, m_out());
            end
            n_checks++;
            if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h1000_0000 + 32'(k), 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL seq_word k=%0d got=%h/%h exp=%h/%h", k, inst, inst_pc,
                         32'h1000_0000 + 32'(k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 32'h0, 1'b0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL bp_hold k=%0d got=%h exp=%h", k, dut_out, m_out());
            end
        end
        n_checks++;
        if ({imem_addr, inst, inst_pc} !== {32'h8, 32'h1000_0000, 32'h0}) begin
            n_fail++;
            $display("FAIL bp_stuck got addr=%h inst=%h pc=%h exp addr=8 inst=10000000 pc=0",
                     imem_addr, inst, inst_pc);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 32'h0, 1'b1);
            n_checks++;
            if ({inst_valid, inst_pc, dut_out} !== {1'b1, 32'(4 * (k + 1)), m_out()}) begin
                n_fail++;
                $display("FAIL bp_resume k=%0d got pc=%h exp pc=%h", k, inst_pc, 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h0000_0043, 1'b0);
        n_checks++;
        if ({inst_valid, imem_addr} !== {1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL redir_flush got valid=%b addr=%h exp valid=0 addr=40", inst_valid, imem_addr);
        end
        tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, 32'h1000_0010}) begin
            n_fail++;
            $display("FAIL redir_target got pc=%h inst=%h exp pc=40 inst=10000010", inst_pc, inst);
        end
        n_checks++;
        if (dut_out !== m_out()) begin
            n_fail++;
            $display("FAIL redir_model got=%h exp=%h", dut_out, m_out());
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h0000_0100, 1'b1);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (inst_valid && (inst_pc === 32'h4 || inst_pc === 32'h0)) begin
                n_fail++;
                $display("FAIL redir_pop_stale k=%0d got pc=%h exp pc>=100", k, inst_pc);
            end
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL redir_pop_model k=%0d got=%h exp=%h", k, dut_out, m_out());
            end
            tick(1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h200, 1'b1);
        tick(1'b1, 32'h300, 1'b1);
        tick(1'b1, 32'h406, 1'b1);
        n_checks++;
        if ({inst_valid, imem_addr} !== {1'b0, 32'h404}) begin
            n_fail++;
            $display("FAIL b2b_redir got valid=%b addr=%h exp valid=0 addr=404", inst_valid, imem_addr);
        end
        tick(1'b0, 32'h0, 1'b1);
        n_checks++;
        if ({inst_valid, inst_pc, inst_pc4} !== {1'b1, 32'h404, 32'h408}) begin
            n_fail++;
            $display("FAIL b2b_target got pc=%h pc4=%h exp pc=404 pc4=408", inst_pc, inst_pc4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_out !== {1'b0, 96'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", dut_out, {1'b0, 96'b0, 32'h0});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic rv, dr;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 9) == 0);
            dr  = ($urandom_range(0, 2) != 0);
            rpc = $urandom;
            tick(rv, rpc, dr);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL rand_model k=%0d got=%h exp=%h", k, dut_out, m_out());
            end
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== {m_fetch, m_stall}) begin
            n_fail++;
            $display("FAIL rand_perf got=%0d/%0d exp=%0d/%0d", perf_fetch_cnt, perf_stall_cnt,
                     m_fetch, m_stall);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        @(negedge clk);
        reset2 = 1'b0;
        dec_ready2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({inst_valid2, inst_pc2, inst_pc42, inst2} !==
                {1'b1, exp_pc[k], exp_pc[k] + 32'd4, rom(exp_pc[k])}) begin
                n_fail++;
                $display("FAIL wrap k=%0d got pc=%h pc4=%h exp pc=%h pc4=%h", k, inst_pc2, inst_pc42,
                         exp_pc[k], exp_pc[k] + 32'd4);
            end
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_fetch_cnt2 !== 32'd3) begin
            n_fail++;
            $display("FAIL wrap_perf got=%0d exp=3", perf_fetch_cnt2);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
